// File: rtl/johnson_updown_counter.sv
// johnson_updown_counter: bidirectional Johnson ring with load, enable, wrap pulse and illegal-code recovery
module johnson_updown_counter #(
    parameter int WIDTH = 4,
    parameter int IDXW = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] signal,
    output logic [IDXW-1:0]  index,
    output logic             wrap,
    output logic             err
);
    localparam logic [IDXW-1:0] LAST = IDXW'(2 * WIDTH - 1);
    // A legal Johnson code has at most one boundary between adjacent differing bits
    function automatic logic legal(input logic [WIDTH-1:0] v);
        return $countones(v[WIDTH-1:1] ^ v[WIDTH-2:0]) <= 1;
    endfunction
    function automatic logic [IDXW-1:0] pos(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? IDXW'(2 * WIDTH - $countones(v)) : IDXW'($countones(v));
    endfunction
    logic [WIDTH-1:0] sig_n;
    logic             wrap_n;
    logic             err_n;
    always_comb begin
        sig_n  = signal;
        wrap_n = 1'b0;
        err_n  = 1'b0;
        if (load) begin
            sig_n = legal(load_val) ? load_val : '0;
            err_n = !legal(load_val);
        end else if (!legal(signal)) begin
            sig_n = '0;
            err_n = 1'b1;
        end else if (en) begin
            sig_n  = dir ? {signal[WIDTH-2:0], ~signal[WIDTH-1]} : {~signal[0], signal[WIDTH-1:1]};
            wrap_n = dir ? index == LAST : index == '0;
        end
    end
    // Index is derived from the next code so it is registered in step with signal
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            signal <= '0;
            index  <= '0;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else begin
            signal <= sig_n;
            index  <= pos(sig_n);
            wrap   <= wrap_n;
            err    <= err_n;
        end
    end
endmodule

// File: tb/tb_johnson_updown_counter.sv
// tb_johnson_updown_counter: scoreboard bench for WIDTH=4 and WIDTH=6 Johnson counters
module tb_johnson_updown_counter;
    logic       clk = 1'b0;
    logic       reset4, en4, dir4, load4;
    logic [3:0] load_val4, sig4;
    logic [2:0] idx4;
    logic       wrap4, err4;
    logic       reset6, en6, dir6;
    logic [5:0] sig6;
    logic [3:0] idx6;
    logic       wrap6, err6;
    typedef struct {
        string      name;
        logic [7:0] s;
        logic [7:0] i;
        logic       w;
        logic       e;
    } exp_t;
    exp_t q4[$];
    exp_t q6[$];
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    johnson_updown_counter #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset4), .en(en4), .dir(dir4), .load(load4), .load_val(load_val4),
        .signal(sig4), .index(idx4), .wrap(wrap4), .err(err4)
    );
    johnson_updown_counter #(.WIDTH(6)) dut6 (
        .clk(clk), .reset(reset6), .en(en6), .dir(dir6), .load(1'b0), .load_val(6'b0),
        .signal(sig6), .index(idx6), .wrap(wrap6), .err(err6)
    );
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            chk({e.name, " signal4"}, {4'b0, sig4}, e.s);
            chk({e.name, " index4"}, {5'b0, idx4}, e.i);
            chk({e.name, " wrap4"}, {7'b0, wrap4}, {7'b0, e.w});
            chk({e.name, " err4"}, {7'b0, err4}, {7'b0, e.e});
        end
        if (q6.size() > 0) begin
            e = q6.pop_front();
            chk({e.name, " signal6"}, {2'b0, sig6}, e.s);
            chk({e.name, " index6"}, {4'b0, idx6}, e.i);
            chk({e.name, " wrap6"}, {7'b0, wrap6}, {7'b0, e.w});
            chk({e.name, " err6"}, {7'b0, err6}, {7'b0, e.e});
        end
    end
    task automatic step4(input logic r, input logic e, input logic d, input logic l, input logic [3:0] lv,
                         input string n, input logic [3:0] s, input logic [2:0] i, input logic w, input logic er);
        @(negedge clk);
        reset4 = r; en4 = e; dir4 = d; load4 = l; load_val4 = lv;
        q4.push_back('{n, {4'b0, s}, {5'b0, i}, w, er});
    endtask
    task automatic step6(input logic r, input logic e, input logic d,
                         input string n, input logic [5:0] s, input logic [3:0] i, input logic w);
        @(negedge clk);
        reset6 = r; en6 = e; dir6 = d;
        q6.push_back('{n, {2'b0, s}, {4'b0, i}, w, 1'b0});
    endtask
    initial begin
        reset4 = 1'b0; en4 = 1'b0; dir4 = 1'b0; load4 = 1'b0; load_val4 = 4'b0;
        reset6 = 1'b0; en6 = 1'b0; dir6 = 1'b0;
        step4(0, 1, 1, 0, 4'b0, "rst_a", 4'b0000, 3'd0, 0, 0);
        step4(0, 1, 1, 0, 4'b0, "rst_b", 4'b0000, 3'd0, 0, 0);
        step4(1, 1, 1, 0, 4'b0, "up1", 4'b0001, 3'd1, 0, 0);
        step4(1, 1, 1, 0, 4'b0, "up2", 4'b0011, 3'd2, 0, 0);
        step4(1, 1, 1, 0, 4'b0, "up3", 4'b0111, 3'd3, 0, 0);
        step4(1, 1, 1, 0, 4'b0, "up4", 4'b1111, 3'd4, 0, 0);
        step4(1, 1, 1, 0, 4'b0, "up5", 4'b1110, 3'd5, 0, 0);
        step4(1, 1, 1, 0, 4'b0, "up6", 4'b1100, 3'd6, 0, 0);
        step4(1, 1, 1, 0, 4'b0, "up7", 4'b1000, 3'd7, 0, 0);
        step4(1, 1, 1, 0, 4'b0, "up8", 4'b0000, 3'd0, 1, 0);
        step4(1, 1, 0, 0, 4'b0, "dn1", 4'b1000, 3'd7, 1, 0);
        step4(1, 1, 0, 0, 4'b0, "dn2", 4'b1100, 3'd6, 0, 0);
        step4(1, 1, 0, 0, 4'b0, "dn3", 4'b1110, 3'd5, 0, 0);
        step4(1, 1, 0, 0, 4'b0, "dn4", 4'b1111, 3'd4, 0, 0);
        step4(1, 1, 0, 0, 4'b0, "dn5", 4'b0111, 3'd3, 0, 0);
        step4(1, 1, 0, 0, 4'b0, "dn6", 4'b0011, 3'd2, 0, 0);
        step4(1, 1, 0, 0, 4'b0, "dn7", 4'b0001, 3'd1, 0, 0);
        step4(1, 1, 0, 0, 4'b0, "dn8", 4'b0000, 3'd0, 0, 0);
        step4(1, 1, 1, 0, 4'b0, "mid1", 4'b0001, 3'd1, 0, 0);
        step4(1, 1, 1, 0, 4'b0, "mid2", 4'b0011, 3'd2, 0, 0);
        step4(1, 1, 1, 0, 4'b0, "mid3", 4'b0111, 3'd3, 0, 0);
        for (int k = 0; k < 3; k++) step4(1, 0, 1, 0, 4'b0, "hold", 4'b0111, 3'd3, 0, 0);
        step4(1, 0, 0, 0, 4'b0, "hold_flip", 4'b0111, 3'd3, 0, 0);
        step4(1, 1, 0, 0, 4'b0, "flip_dn", 4'b0011, 3'd2, 0, 0);
        step4(1, 1, 1, 1, 4'b1100, "load_ok", 4'b1100, 3'd6, 0, 0);
        step4(1, 1, 1, 1, 4'b0101, "load_bad", 4'b0000, 3'd0, 0, 1);
        step4(1, 0, 1, 0, 4'b0, "err_clr", 4'b0000, 3'd0, 0, 0);
        step4(1, 1, 1, 1, 4'b1000, "load_7", 4'b1000, 3'd7, 0, 0);
        step4(1, 1, 1, 0, 4'b0, "wrap_after_load", 4'b0000, 3'd0, 1, 0);
        @(negedge clk);
        en4 = 1'b0;
        force dut4.signal = 4'b1010;
        #1 release dut4.signal;
        q4.push_back('{"seu_fix", 8'h00, 8'h00, 1'b0, 1'b1});
        step4(1, 1, 1, 0, 4'b0, "seu_resume", 4'b0001, 3'd1, 0, 0);
        step4(1, 1, 1, 0, 4'b0, "seu_next", 4'b0011, 3'd2, 0, 0);
        step6(0, 0, 1, "w6_rst", 6'b000000, 4'd0, 0);
        step6(1, 1, 1, "w6_u1", 6'b000001, 4'd1, 0);
        step6(1, 1, 1, "w6_u2", 6'b000011, 4'd2, 0);
        step6(1, 1, 1, "w6_u3", 6'b000111, 4'd3, 0);
        step6(1, 1, 1, "w6_u4", 6'b001111, 4'd4, 0);
        step6(1, 1, 1, "w6_u5", 6'b011111, 4'd5, 0);
        step6(1, 1, 1, "w6_u6", 6'b111111, 4'd6, 0);
        step6(1, 1, 1, "w6_u7", 6'b111110, 4'd7, 0);
        step6(1, 1, 1, "w6_u8", 6'b111100, 4'd8, 0);
        step6(1, 1, 1, "w6_u9", 6'b111000, 4'd9, 0);
        step6(1, 1, 1, "w6_u10", 6'b110000, 4'd10, 0);
        step6(1, 1, 1, "w6_u11", 6'b100000, 4'd11, 0);
        step6(1, 1, 1, "w6_u12", 6'b000000, 4'd0, 1);
        step6(1, 1, 1, "w6_v1", 6'b000001, 4'd1, 0);
        step6(1, 1, 1, "w6_v2", 6'b000011, 4'd2, 0);
        step6(1, 1, 1, "w6_v3", 6'b000111, 4'd3, 0);
        step6(1, 1, 1, "w6_v4", 6'b001111, 4'd4, 0);
        step6(1, 1, 1, "w6_v5", 6'b011111, 4'd5, 0);
        @(negedge clk);
        #2 reset6 = 1'b0;
        #1;
        chk("w6_async_signal", {2'b0, sig6}, 8'h00);
        chk("w6_async_index", {4'b0, idx6}, 8'h00);
        step6(0, 1, 1, "w6_held", 6'b000000, 4'd0, 0);
        step6(1, 1, 1, "w6_release", 6'b000001, 4'd1, 0);
        repeat (2) @(posedge clk);
        #2;
        chk("q4_drained", 8'(q4.size()), 8'h00);
        chk("q6_drained", 8'(q6.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
